// File: rtl/spu_pkg.sv
// Shared SPU MEM-stage types: widths, FSM state encoding, and the registered WB bundle.
package spu_pkg;
  localparam int QW_W      = 128;
  localparam int REG_W     = 7;
  localparam int LS_ADDR_W = 18;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [QW_W-1:0]  data;
    logic [REG_W-1:0] rt;
  } wb_bundle_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB register: one cycle, takes the ALU bundle or the completed local-store access,
// otherwise inserts a bubble while keeping data/rt.
module mem_wb_reg
  import spu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_alu_i,
  input  logic             upd_mem_i,
  input  wb_bundle_t       alu_i,
  input  logic             mem_load_i,
  input  logic [QW_W-1:0]  mem_rdata_i,
  input  logic [REG_W-1:0] mem_rt_i,
  output wb_bundle_t       wb_o
);

  wb_bundle_t wb_q, wb_d;

  always_comb begin
    wb_d = wb_q;
    if (upd_alu_i) begin
      wb_d = alu_i;
    end else if (upd_mem_i) begin
      wb_d.valid    = 1'b1;
      wb_d.regwrite = mem_load_i;
      wb_d.rt       = mem_rt_i;
      // Stores leave the previous writeback data in place.
      if (mem_load_i) wb_d.data = mem_rdata_i;
    end else begin
      wb_d.valid    = 1'b0;
      wb_d.regwrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign wb_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// SPU MEM stage: quadword local-store access via req/ack (stalls upstream while outstanding),
// branch resolution, and the MEM/WB register. Non-memory ops take 1 cycle, memory ops 2+.
module mem_stage #(
  parameter int LS_ADDR_W = 18,
  parameter int DATA_W    = 128,
  parameter int REG_W     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic                 RegWrite_in,
  input  logic                 Branch_in,
  input  logic                 zero_in,
  input  logic [31:0]          JumpPC_in,
  input  logic [DATA_W-1:0]    ALUResult_in,
  input  logic [DATA_W-1:0]    ReadData2_in,
  input  logic [REG_W-1:0]     RegisterRT_in,
  output logic                 ls_req,
  output logic                 ls_we,
  output logic [LS_ADDR_W-1:0] ls_addr,
  output logic [DATA_W-1:0]    ls_wdata,
  input  logic                 ls_ack,
  input  logic [DATA_W-1:0]    ls_rdata,
  output logic                 stall_out,
  output logic                 PCSrc_out,
  output logic [31:0]          BranchTarget_out,
  output logic                 wb_valid,
  output logic                 RegWrite_out,
  output logic [DATA_W-1:0]    WriteData_out,
  output logic [REG_W-1:0]     RegisterRT_out
);

  import spu_pkg::*;

  mem_state_t state_q, state_d;

  logic                 memop;
  logic                 issue, complete, alu_pass;
  logic                 ls_req_q, ls_req_d;
  logic                 ls_we_q, ls_we_d;
  logic [LS_ADDR_W-1:0] ls_addr_q, ls_addr_d;
  logic [DATA_W-1:0]    ls_wdata_q, ls_wdata_d;
  logic [REG_W-1:0]     rt_q, rt_d;
  logic                 load_q, load_d;
  logic                 pcsrc_q, pcsrc_d;
  logic [31:0]          btgt_q, btgt_d;
  wb_bundle_t           alu_wb, wb;

  assign memop = valid_in & (MemRead_in | MemWrite_in);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memop)  state_d = WAIT;
      WAIT:    if (ls_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ls_ack is only meaningful in WAIT; in IDLE it never reaches any strobe.
  always_comb begin
    issue     = 1'b0;
    complete  = 1'b0;
    alu_pass  = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        issue     = memop;
        alu_pass  = !memop;
        stall_out = memop;
      end
      WAIT: begin
        complete  = ls_ack;
        stall_out = !ls_ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    ls_req_d   = ls_req_q;
    ls_we_d    = ls_we_q;
    ls_addr_d  = ls_addr_q;
    ls_wdata_d = ls_wdata_q;
    rt_d       = rt_q;
    load_d     = load_q;
    pcsrc_d    = 1'b0;
    btgt_d     = btgt_q;
    if (issue) begin
      ls_req_d   = 1'b1;
      ls_we_d    = MemWrite_in;
      ls_addr_d  = {ALUResult_in[LS_ADDR_W-1:4], 4'b0};
      ls_wdata_d = ReadData2_in;
      rt_d       = RegisterRT_in;
      // Read+write together behaves as a store, so no register write.
      load_d     = MemRead_in & !MemWrite_in;
    end
    if (complete) ls_req_d = 1'b0;
    if (alu_pass) begin
      pcsrc_d = valid_in & Branch_in & zero_in;
      btgt_d  = JumpPC_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ls_req_q   <= 1'b0;
      ls_we_q    <= 1'b0;
      ls_addr_q  <= '0;
      ls_wdata_q <= '0;
      rt_q       <= '0;
      load_q     <= 1'b0;
      pcsrc_q    <= 1'b0;
      btgt_q     <= '0;
    end else begin
      ls_req_q   <= ls_req_d;
      ls_we_q    <= ls_we_d;
      ls_addr_q  <= ls_addr_d;
      ls_wdata_q <= ls_wdata_d;
      rt_q       <= rt_d;
      load_q     <= load_d;
      pcsrc_q    <= pcsrc_d;
      btgt_q     <= btgt_d;
    end
  end

  always_comb begin
    alu_wb          = '0;
    alu_wb.valid    = valid_in;
    alu_wb.regwrite = valid_in & RegWrite_in;
    alu_wb.data     = ALUResult_in;
    alu_wb.rt       = RegisterRT_in;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .upd_alu_i   (alu_pass),
    .upd_mem_i   (complete),
    .alu_i       (alu_wb),
    .mem_load_i  (load_q),
    .mem_rdata_i (ls_rdata),
    .mem_rt_i    (rt_q),
    .wb_o        (wb)
  );

  assign ls_req           = ls_req_q;
  assign ls_we            = ls_we_q;
  assign ls_addr          = ls_addr_q;
  assign ls_wdata         = ls_wdata_q;
  assign PCSrc_out        = pcsrc_q;
  assign BranchTarget_out = btgt_q;
  assign wb_valid         = wb.valid;
  assign RegWrite_out     = wb.regwrite;
  assign WriteData_out    = wb.data;
  assign RegisterRT_out   = wb.rt;

endmodule
